// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte producers, the round-robin arbiter and the shared uart_tx core.
// master = arbiter side, slave = producers/transmitter side.
interface uart_tx_arbiter_if #(
  parameter int unsigned N = 4
);
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic [N-1:0]   grant;
  logic           err_to;

  modport master (
    input  req_valid, req_data, tx_busy,
    output req_ready, tx_start, tx_data, grant, err_to
  );

  modport slave (
    output req_valid, req_data, tx_busy,
    input  req_ready, tx_start, tx_data, grant, err_to
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 uart_tx among N byte requesters.
// Define UART_ARB_TAG_EN to precede every data byte with a {TAG_HI, 0, channel} tag byte.
module uart_tx_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned BUSY_TO = 16
`ifdef UART_ARB_TAG_EN
  ,
  parameter logic [3:0]  TAG_HI  = 4'hA
`endif
) (
  input logic               clk,
  input logic               rst,
  uart_tx_arbiter_if.master bus
);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = $clog2(BUSY_TO) + 1;

  typedef enum logic [1:0] {StIdle, StStart, StWaitBusy, StWaitDone} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   last_q, last_d, win;
  logic            win_vld;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [N-1:0]    grant_q, grant_d;
  logic            tx_start_q, tx_start_d;
  logic            err_to_q, err_to_d;
  logic            accept, timeout, more_pass;
  logic [7:0]      win_data;

`ifdef UART_ARB_TAG_EN
  logic            tag_q, tag_d;
  logic [7:0]      byte_q, byte_d;
  assign more_pass = tag_q;
`else
  assign more_pass = 1'b0;
`endif

  // Scan downward so the nearest valid index after last_q is the one left standing.
  always_comb begin
    win     = last_q;
    win_vld = 1'b0;
    for (int unsigned k = N; k >= 1; k--) begin
      if (bus.req_valid[IW'((32'(last_q) + k) % N)]) begin
        win     = IW'((32'(last_q) + k) % N);
        win_vld = 1'b1;
      end
    end
  end

  assign win_data = bus.req_data[{win, 3'b000} +: 8];
  assign accept   = (state_q == StIdle) && win_vld && !bus.tx_busy;
  // Decided one cycle early so the registered err_to lands BUSY_TO cycles after tx_start.
  assign timeout  = (state_q == StWaitBusy) && !bus.tx_busy && (cnt_q == CW'(BUSY_TO - 2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (accept) state_d = StStart;
      StStart:    state_d = StWaitBusy;
      StWaitBusy: begin
        if (bus.tx_busy)  state_d = StWaitDone;
        else if (timeout) state_d = StIdle;
      end
      StWaitDone: if (!bus.tx_busy) state_d = more_pass ? StStart : StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    last_d     = last_q;
    grant_d    = grant_q;
    tx_data_d  = tx_data_q;
    cnt_d      = cnt_q;
    tx_start_d = 1'b0;
    err_to_d   = 1'b0;
`ifdef UART_ARB_TAG_EN
    tag_d      = tag_q;
    byte_d     = byte_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          last_d     = win;
          grant_d    = N'(1) << win;
          tx_start_d = 1'b1;
`ifdef UART_ARB_TAG_EN
          tx_data_d  = {TAG_HI, 1'b0, 3'(win)};
          byte_d     = win_data;
          tag_d      = 1'b1;
`else
          tx_data_d  = win_data;
`endif
        end
      end
      StStart:    cnt_d = '0;
      StWaitBusy: begin
        cnt_d = cnt_q + CW'(1);
        if (timeout) begin
          err_to_d = 1'b1;
          grant_d  = '0;
`ifdef UART_ARB_TAG_EN
          tag_d    = 1'b0;
`endif
        end
      end
      StWaitDone: begin
        if (!bus.tx_busy) begin
          if (more_pass) begin
            tx_start_d = 1'b1;
`ifdef UART_ARB_TAG_EN
            tx_data_d  = byte_q;
            tag_d      = 1'b0;
`endif
          end else begin
            grant_d = '0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q     <= IW'(N - 1);
      grant_q    <= '0;
      tx_data_q  <= '0;
      cnt_q      <= '0;
      tx_start_q <= 1'b0;
      err_to_q   <= 1'b0;
`ifdef UART_ARB_TAG_EN
      tag_q      <= 1'b0;
      byte_q     <= '0;
`endif
    end else begin
      last_q     <= last_d;
      grant_q    <= grant_d;
      tx_data_q  <= tx_data_d;
      cnt_q      <= cnt_d;
      tx_start_q <= tx_start_d;
      err_to_q   <= err_to_d;
`ifdef UART_ARB_TAG_EN
      tag_q      <= tag_d;
      byte_q     <= byte_d;
`endif
    end
  end

  // req_ready is the only combinational output; hold it low while reset is asserted.
  always_comb begin
    bus.req_ready = '0;
    if (accept && !rst) bus.req_ready = N'(1) << win;
  end

  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.grant    = grant_q;
  assign bus.err_to   = err_to_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple uart_tx busy responder and an
// expected-byte scoreboard checked on every tx_start.
module tb_uart_tx_arbiter;
  localparam int unsigned N       = 4;
  localparam int unsigned BUSY_TO = 16;
`ifdef UART_ARB_TAG_EN
  localparam logic [7:0]  T1_FIRST   = 8'hA2;
  localparam int          EXP_STARTS = 32;
  localparam int          T6_STARTS  = 2;
`else
  localparam logic [7:0]  T1_FIRST   = 8'h55;
  localparam int          EXP_STARTS = 17;
  localparam int          T6_STARTS  = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic model_busy = 1'b0;
  logic ext_busy = 1'b0;
  logic uart_en = 1'b1;

  int checks = 0;
  int failures = 0;
  int starts = 0;
  int errs = 0;
  int rem [N];
  logic [N-1:0] last_rdy, last_acc;
  logic [11:0]  exp_q [$];

  uart_tx_arbiter_if #(.N(N)) bus ();
  assign bus.tx_busy = model_busy | ext_busy;

  uart_tx_arbiter #(.N(N), .BUSY_TO(BUSY_TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each expected entry is {grant, tx_data} as seen on a tx_start cycle.
  task automatic expect_byte(input int ch, input logic [7:0] d);
`ifdef UART_ARB_TAG_EN
    exp_q.push_back({4'(1 << ch), 4'hA, 1'b0, 3'(ch)});
`endif
    exp_q.push_back({4'(1 << ch), d});
  endtask

  task automatic load(input int ch, input int cnt, input logic [7:0] d);
    rem[ch] = cnt;
    bus.req_data[ch*8 +: 8] = d;
    bus.req_valid[ch] = 1'b1;
  endtask

  // One clock: sample the handshake mid-cycle, then retire accepted bytes after the edge.
  task automatic step();
    @(negedge clk);
    last_rdy = bus.req_ready;
    last_acc = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (last_acc[i]) begin
        rem[i]--;
        if (rem[i] <= 0) bus.req_valid[i] = 1'b0;
        else bus.req_data[i*8 +: 8] = bus.req_data[i*8 +: 8] + 8'd1;
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(exp_q.size() == 0 && bus.grant == '0 && !bus.tx_busy && bus.req_valid == '0)
               && n < 600);
    check(tag, 32'(n < 600), 1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // uart_tx stand-in: busy rises two cycles after tx_start and holds for six cycles.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (uart_en && bus.tx_start) begin
        repeat (2) @(posedge clk);
        #1;
        model_busy = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        model_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    logic [11:0] e;
    if (!rst) begin
      if (bus.tx_start || bus.err_to)
        check("start_err_exclusive", 32'(bus.tx_start & bus.err_to), 0);
      if (bus.tx_start) begin
        starts++;
        // 12'hFFF can never match a one-hot grant, so an unexpected start always fails.
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hFFF;
        check("start_grant_data", 32'({bus.grant, bus.tx_data}), 32'(e));
      end
      if (bus.err_to) errs++;
    end
  end

  initial begin
    int n;
    int s0;
    int bad;
    logic ended;
    bus.req_valid = '0;
    bus.req_data  = '0;
    for (int i = 0; i < N; i++) rem[i] = 0;

    // Reset state
    #1;
    check("reset_outputs_during", 32'({bus.req_ready, bus.tx_start, bus.tx_data, bus.grant,
                                        bus.err_to}), 0);
    pulse_reset();
    check("reset_outputs_after", 32'({bus.req_ready, bus.tx_start, bus.tx_data, bus.grant,
                                       bus.err_to}), 0);

    // Single request on ch2
    load(2, 1, 8'h55);
    expect_byte(2, 8'h55);
    step();
    check("t1_ready_onehot", 32'(last_rdy), 32'(4'b0100));
    check("t1_start_latency", 32'(bus.tx_start), 1);
    check("t1_grant", 32'(bus.grant), 32'(4'b0100));
    check("t1_tx_data", 32'(bus.tx_data), 32'(T1_FIRST));
    wait_idle("t1_idle");

    // All four valid right after reset: ch0..ch3 in order
    pulse_reset();
    for (int i = 0; i < N; i++) begin
      load(i, 1, 8'hC0 + 8'(i));
      expect_byte(i, 8'hC0 + 8'(i));
    end
    wait_idle("t2_idle");

    // Fairness: ch0 and ch3 continuously valid alternate
    load(0, 3, 8'h10);
    load(3, 3, 8'h30);
    for (int k = 0; k < 3; k++) begin
      expect_byte(0, 8'h10 + 8'(k));
      expect_byte(3, 8'h30 + 8'(k));
    end
    wait_idle("t3_idle");

    // External TX user holds busy: nothing accepted; a withdrawn request takes no byte
    ext_busy = 1'b1;
    load(1, 1, 8'h99);
    repeat (3) step();
    check("busy_hold_ready", 32'(last_rdy), 0);
    check("busy_hold_grant", 32'(bus.grant), 0);
    bus.req_valid[1] = 1'b0;
    rem[1] = 0;
    ext_busy = 1'b0;
    s0 = starts;
    repeat (4) step();
    check("withdrawn_no_start", 32'(starts - s0), 0);
    load(1, 1, 8'h99);
    expect_byte(1, 8'h99);
    wait_idle("busy_release_idle");

    // Timeout: busy never rises
    uart_en = 1'b0;
    load(1, 1, 8'h77);
    expect_byte(1, 8'h77);
    n = 0;
    while (!bus.tx_start && n < 50) begin
      step();
      n++;
    end
    check("to_start_seen", 32'(bus.tx_start), 1);
    n = 0;
    while (!bus.err_to && n < 3 * BUSY_TO) begin
      step();
      n++;
    end
    check("to_latency", 32'(n), BUSY_TO);
    check("to_grant_clear", 32'(bus.grant), 0);
`ifdef UART_ARB_TAG_EN
    void'(exp_q.pop_front());
`endif
    step();
    check("to_single_pulse", 32'(bus.err_to), 0);
    uart_en = 1'b1;
    wait_idle("to_idle");

    // Reset during WAIT_DONE: silent abort, ch0 wins over ch2 afterwards
    load(0, 1, 8'h11);
    expect_byte(0, 8'h11);
    n = 0;
    while (!(bus.tx_busy && bus.grant != '0) && n < 50) begin
      step();
      n++;
    end
    check("rst_reached_wait_done", 32'(n < 50), 1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("rst_mid_outputs", 32'({bus.req_ready, bus.tx_start, bus.tx_data, bus.grant,
                                   bus.err_to}), 0);
    load(0, 1, 8'h21);
    load(2, 1, 8'h23);
    #1;
    check("rst_mid_ready_gated", 32'(bus.req_ready), 0);
    expect_byte(0, 8'h21);
    expect_byte(2, 8'h23);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_idle("rst_mid_idle");

    // ch1 sends 0x3C; grant stays 0010 for the whole transfer
    s0 = starts;
    bad = 0;
    ended = 1'b0;
    load(1, 1, 8'h3C);
    expect_byte(1, 8'h3C);
    n = 0;
    while (!ended && n < 200) begin
      step();
      n++;
      if (bus.grant == '0 && starts > s0 && !bus.tx_busy) ended = 1'b1;
      else if (bus.grant != '0 && bus.grant != 4'b0010) bad++;
      else if (bus.grant == '0 && starts > s0) bad++;
    end
    check("t6_grant_held", 32'(bad), 0);
    check("t6_start_count", 32'(starts - s0), T6_STARTS);
    wait_idle("t6_idle");

    check("total_err_to", 32'(errs), 1);
    check("total_starts", 32'(starts), EXP_STARTS);
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
